// File: rtl/id_ex_if.sv
// id_ex_if: D-stage inputs, EX-stage register outputs and hazard/forwarding
// signals of the decode-to-execute boundary.
// master = pipeline side driving decode data, slave = the id_ex_stage block.
interface id_ex_if #(parameter int DW = 32);
   // decode side
   logic          valid_d;
   logic [DW-1:0] rd1_d, rd2_d, imm_d;
   logic [4:0]    rs_d, rt_d, rd_d;
   logic          reg_wr_d, mem_to_reg_d, mem_wr_d, alu_src_d, reg_dst_d;
   logic [2:0]    alu_ctrl_d;
   // redirect and downstream destinations
   logic          flush_e;
   logic [4:0]    wa_m, wa_w;
   logic          reg_wr_m, reg_wr_w;
   // hazard outputs
   logic          stall_f, stall_d;
   // execute side
   logic          valid_e, reg_wr_e, mem_to_reg_e, mem_wr_e, alu_src_e;
   logic [2:0]    alu_ctrl_e;
   logic [DW-1:0] rd1_e, rd2_e, imm_e;
   logic [4:0]    rs_e, rt_e, wa_e;
   logic [1:0]    fwd_a_e, fwd_b_e;

   modport master (
      output valid_d, rd1_d, rd2_d, imm_d, rs_d, rt_d, rd_d,
             reg_wr_d, mem_to_reg_d, mem_wr_d, alu_src_d, reg_dst_d, alu_ctrl_d,
             flush_e, wa_m, wa_w, reg_wr_m, reg_wr_w,
      input  stall_f, stall_d, valid_e, reg_wr_e, mem_to_reg_e, mem_wr_e,
             alu_src_e, alu_ctrl_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, wa_e,
             fwd_a_e, fwd_b_e
   );

   modport slave (
      input  valid_d, rd1_d, rd2_d, imm_d, rs_d, rt_d, rd_d,
             reg_wr_d, mem_to_reg_d, mem_wr_d, alu_src_d, reg_dst_d, alu_ctrl_d,
             flush_e, wa_m, wa_w, reg_wr_m, reg_wr_w,
      output stall_f, stall_d, valid_e, reg_wr_e, mem_to_reg_e, mem_wr_e,
             alu_src_e, alu_ctrl_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, wa_e,
             fwd_a_e, fwd_b_e
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage MIPS core.
// Load-use detection with a one-cycle bubble, branch flush, EX forwarding selects.
// Optional macro ID_EX_PERF_EN adds saturating stall_cnt / flush_cnt ports.
module id_ex_stage #(parameter int DW = 32) (
   input  logic        clk,
   input  logic        rst,
   id_ex_if.slave      bus
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef struct packed {
      logic          valid;
      logic          reg_wr;
      logic          mem_to_reg;
      logic          mem_wr;
      logic          alu_src;
      logic [2:0]    alu_ctrl;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] imm;
      logic [4:0]    rs;
      logic [4:0]    rt;
      logic [4:0]    wa;
   } ex_t;

   ex_t  ex_q, ex_n;
   logic lu;

   // Load in EX whose destination is read by the instruction in D; $0 never stalls.
   // rt is compared even for I-type, which costs a rare spurious stall but no decode.
   assign lu = bus.valid_d & ex_q.valid & ex_q.mem_to_reg & (ex_q.wa != 5'd0) &
               ((ex_q.wa == bus.rs_d) | (ex_q.wa == bus.rt_d));

   assign bus.stall_f = lu;
   assign bus.stall_d = lu;

   // Next EX contents: data always captured, controls gated by valid_d.
   always_comb begin
      ex_n            = '0;
      ex_n.valid      = bus.valid_d;
      ex_n.reg_wr     = bus.valid_d & bus.reg_wr_d;
      ex_n.mem_to_reg = bus.valid_d & bus.mem_to_reg_d;
      ex_n.mem_wr     = bus.valid_d & bus.mem_wr_d;
      ex_n.alu_src    = bus.valid_d & bus.alu_src_d;
      ex_n.alu_ctrl   = bus.valid_d ? bus.alu_ctrl_d : 3'd0;
      ex_n.rd1        = bus.rd1_d;
      ex_n.rd2        = bus.rd2_d;
      ex_n.imm        = bus.imm_d;
      ex_n.rs         = bus.rs_d;
      ex_n.rt         = bus.rt_d;
      ex_n.wa         = bus.reg_dst_d ? bus.rd_d : bus.rt_d;
   end

   // EX register: reset, then bubble on stall or flush, else advance.
   always_ff @(posedge clk) begin
      if (rst)               ex_q <= '0;
      else if (lu | bus.flush_e) ex_q <= '0;
      else                   ex_q <= ex_n;
   end

   assign bus.valid_e      = ex_q.valid;
   assign bus.reg_wr_e     = ex_q.reg_wr;
   assign bus.mem_to_reg_e = ex_q.mem_to_reg;
   assign bus.mem_wr_e     = ex_q.mem_wr;
   assign bus.alu_src_e    = ex_q.alu_src;
   assign bus.alu_ctrl_e   = ex_q.alu_ctrl;
   assign bus.rd1_e        = ex_q.rd1;
   assign bus.rd2_e        = ex_q.rd2;
   assign bus.imm_e        = ex_q.imm;
   assign bus.rs_e         = ex_q.rs;
   assign bus.rt_e         = ex_q.rt;
   assign bus.wa_e         = ex_q.wa;

   // MEM result is younger than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (bus.reg_wr_m && (bus.wa_m != 5'd0) && (bus.wa_m == src))      return 2'b10;
      else if (bus.reg_wr_w && (bus.wa_w != 5'd0) && (bus.wa_w == src)) return 2'b01;
      else                                                              return 2'b00;
   endfunction

   assign bus.fwd_a_e = fwd_sel(ex_q.rs);
   assign bus.fwd_b_e = fwd_sel(ex_q.rt);

`ifdef ID_EX_PERF_EN
   // Saturating event counters; a flush coinciding with a stall counts as a stall only.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (lu && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
         if (bus.flush_e && !lu && flush_cnt != 32'hFFFF_FFFF)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule
